// File: rtl/alu_bist_pkg.sv
// Shared definitions for the ALU self-test sequencer: FSM states, bus widths,
// default MISR polynomial and the operand LFSR update.
// Ports: none (package).
package alu_bist_pkg;

  localparam int          SEL_W_DEF     = 5;
  localparam int          STATUS_W      = 4;
  localparam int          SIG_W         = 32;
  localparam logic [31:0] MISR_POLY_DEF = 32'h04C1_1DB7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_DRIVE   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Operand generator: shift left, feedback from taps 31, 21, 1, 0.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

endpackage

// File: rtl/misr32.sv
// 32-bit multiple-input signature register folding one data word per enabled cycle.
// Ports: clk, rst_n (async active-low, clears to 0), clear (load all-ones, wins over en),
//        en (fold data), data[31:0] (word to fold), sig[31:0] (current signature).
module misr32
  import alu_bist_pkg::*;
#(
  parameter logic [31:0] POLY = MISR_POLY_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        en,
  input  logic [31:0] data,
  output logic [31:0] sig
);

  logic [31:0] sig_q;
  logic [31:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clear) begin
      sig_d = 32'hFFFF_FFFF;
    end else if (en) begin
      sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0) ^ data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 32'h0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/alu_bist_sequencer.sv
// Self-test engine for a combinational ALU: on start, sweeps select codes 0..NUM_OPS-1
// over NUM_VEC operand vectors (vector 0 all-zero, the rest from an LFSR), folds every
// F/status response into a MISR and reports pass when the final signature matches.
// Ports: clk, rst_n (async active-low), start, abort | alu_a/alu_b/alu_cin/alu_sel (to ALU),
//        alu_f/alu_status (from ALU) | busy, done, pass, signature.
module alu_bist_sequencer
  import alu_bist_pkg::*;
#(
  parameter int          WIDTH        = 32,
  parameter int          SEL_W        = SEL_W_DEF,
  parameter int          NUM_OPS      = 9,
  parameter int          NUM_VEC      = 4,
  parameter int          SETTLE       = 1,
  parameter logic [31:0] LFSR_SEED    = 32'hACE1_2345,
  parameter logic [31:0] MISR_POLY    = MISR_POLY_DEF,
  parameter logic [31:0] EXPECTED_SIG = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  output logic                alu_cin,
  output logic [SEL_W-1:0]    alu_sel,
  input  logic [WIDTH-1:0]    alu_f,
  input  logic [STATUS_W-1:0] alu_status,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [SIG_W-1:0]    signature
);

  localparam int VEC_W = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SEL_W-1:0] OP_LAST  = SEL_W'(NUM_OPS - 1);
  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VEC - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);

  state_e             state_q, state_d;
  logic [31:0]        lfsr_q, lfsr_d;
  logic [SEL_W-1:0]   op_q, op_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               cin_q, cin_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               misr_clr;
  logic               misr_en;
  logic [31:0]        sig;

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    op_d     = op_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    misr_clr = 1'b0;
    misr_en  = 1'b0;

    if (abort) begin
      // Signature is deliberately left untouched so a cancelled run can be inspected.
      state_d  = ST_IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      pass_d   = 1'b0;
      op_d     = '0;
      vec_d    = '0;
      settle_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d  = ST_LOAD;
            lfsr_d   = LFSR_SEED;
            vec_d    = '0;
            busy_d   = 1'b1;
            done_d   = 1'b0;
            pass_d   = 1'b0;
            misr_clr = 1'b1;
          end else if (state_q == ST_DONE) begin
            // Flags go up one cycle after the last fold, once the signature is final.
            busy_d = 1'b0;
            done_d = 1'b1;
            pass_d = (sig == EXPECTED_SIG);
          end
        end
        ST_LOAD: begin
          if (vec_q == '0) begin
            a_d   = '0;
            b_d   = '0;
            cin_d = 1'b0;
          end else begin
            a_d   = WIDTH'(lfsr_q);
            b_d   = WIDTH'({lfsr_q[15:0], lfsr_q[31:16]});
            cin_d = lfsr_q[0];
          end
          lfsr_d   = lfsr_next(lfsr_q);
          op_d     = '0;
          settle_d = '0;
          state_d  = ST_DRIVE;
        end
        ST_DRIVE: begin
          if (settle_q == SET_LAST) begin
            settle_d = '0;
            state_d  = ST_CAPTURE;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
        ST_CAPTURE: begin
          misr_en = 1'b1;
          if (op_q < OP_LAST) begin
            op_d    = op_q + 1'b1;
            state_d = ST_DRIVE;
          end else if (vec_q < VEC_LAST) begin
            vec_d   = vec_q + 1'b1;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= LFSR_SEED;
      op_q     <= '0;
      vec_q    <= '0;
      settle_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      op_q     <= op_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  misr32 #(
    .POLY (MISR_POLY)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (misr_clr),
    .en    (misr_en),
    .data  (32'(alu_f) ^ {28'b0, alu_status}),
    .sig   (sig)
  );

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_cin   = cin_q;
  assign alu_sel   = op_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig;

endmodule
